bus_arbiter: RTL

Two-master arbiter in front of the CPU-side port of the bus interface unit, letting the CPU data port (master 0) and the text/GPU copy engine (master 1) share one address space: MIO, Wishbone data, Wishbone char, text RAM, gpu_status. It uses round-robin fairness and holds a grant until the slave returns ready. An optional watchdog terminates transfers whose Wishbone ack never arrives.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/bus_arb_wdog.sv | 36 +++
 rtl/bus_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Watchdog build option: BUS_ARB_WATCHDOG_EN.
package bus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/bus_arb_wdog.sv
// Stall counter for the arbiter; raises tc_o once it has
// counted TIMEOUT stalled BUSY cycles.
module bus_arb_wdog #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the BIU CPU port between two masters.
// Define BUS_ARB_WATCHDOG_EN to build the stalled-ack watchdog.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ready_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ready_o,
    output logic        m1_err_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i,
    input  logic        s_ready_i,
    output logic        busy_o,
    output logic        owner_o,
    output logic [31:0] to_addr_o
);

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   prio_q, prio_d;
    logic   busy;
    logic   own_req;
    logic   done;
    logic   err;
    logic   tc;

    assign busy    = (state_q == BUSY);
    assign own_req = owner_q ? m1_req_i : m0_req_i;

    // Ready beats the terminal count; a dropped request aborts silently.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_req_i | m1_req_i) begin
                    state_d = BUSY;
                    owner_d = (m0_req_i & m1_req_i) ? ~prio_q : m1_req_i;
                end
            end
            BUSY: begin
                if (!own_req) begin
                    state_d = IDLE;
                end else if (s_ready_i || tc) begin
                    done    = 1'b1;
                    err     = ~s_ready_i;
                    prio_d  = owner_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= M_CPU;
            prio_q  <= M_DMA;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

`ifdef BUS_ARB_WATCHDOG_EN
    logic [31:0] to_addr_q, to_addr_d;

    bus_arb_wdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr_i (~busy),
        .en_i  (busy & ~s_ready_i),
        .tc_o  (tc)
    );

    always_comb begin
        to_addr_d = to_addr_q;
        if (done && err) begin
            to_addr_d = s_addr_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_addr_q <= '0;
        end else begin
            to_addr_q <= to_addr_d;
        end
    end

    assign to_addr_o = to_addr_q;
`else
    // Watchdog parameters have no effect here; tc is constant low.
    assign tc        = (CNT_W < 0) && (TIMEOUT < 0);
    assign to_addr_o = '0;
`endif

    assign s_req_o   = busy;
    assign s_we_o    = busy & (owner_q ? m1_we_i : m0_we_i);
    assign s_addr_o  = busy ? (owner_q ? m1_addr_i : m0_addr_i) : '0;
    assign s_wdata_o = busy ? (owner_q ? m1_wdata_i : m0_wdata_i) : '0;

    assign m0_ready_o = done & (owner_q == M_CPU);
    assign m1_ready_o = done & (owner_q == M_DMA);
    assign m0_err_o   = err & (owner_q == M_CPU);
    assign m1_err_o   = err & (owner_q == M_DMA);

    assign m0_rdata_o = (m0_ready_o & ~err) ? s_rdata_i : '0;
    assign m1_rdata_o = (m1_ready_o & ~err) ? s_rdata_i : '0;

    assign busy_o  = busy;
    assign owner_o = owner_q;

endmodule
